conv_tile_loader: RTL

Fills the conv engine's input-feature-map and weight tile buffers from a valid/ready word stream (DMA side), then launches the convolution. Write-side counterpart of the conv controller, which only reads these buffers. Owns the load → run → wait-done sequence for one tile.
- Sits between the memory streamer and the conv controller / tile buffers.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/tile_addr_gen.sv | 36 +++
 rtl/conv_tile_loader.sv | 97 +++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and defaults for the conv tile loader and its address generator.
package cnn_pkg;
  localparam int NCH_DEF = 8;
  localparam int NWORD_DEF = 32;
  localparam int DW_DEF = 32;
  localparam logic SEL_IFM = 1'b0;
  localparam logic SEL_WGT = 1'b1;
  typedef enum logic [2:0] {
    IDLE,
    LOAD_IFM,
    LOAD_WGT,
    RUN,
    WAIT_DONE
  } ld_state_e;
endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: channel/word write counter, word index fastest, with clear and last-beat flag.
module tile_addr_gen #(
  parameter int NCH = cnn_pkg::NCH_DEF,
  parameter int NWORD = cnn_pkg::NWORD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic [7:0]               nif_i,
  input  logic [7:0]               nwords_i,
  output logic [$clog2(NCH)-1:0]   ch_o,
  output logic [$clog2(NWORD)-1:0] addr_o,
  output logic                     last_o
);
  logic [$clog2(NCH)-1:0] ch_q, ch_d;
  logic [$clog2(NWORD)-1:0] addr_q, addr_d;
  logic wrap;
  assign wrap = 8'(addr_q) == nwords_i - 8'd1;
  assign last_o = wrap && 8'(ch_q) == nif_i - 8'd1;
  assign ch_o = ch_q;
  assign addr_o = addr_q;
  always_comb begin
    ch_d = clr_i ? '0 : (en_i && wrap) ? ch_q + 1'b1 : ch_q;
    addr_d = clr_i ? '0 : !en_i ? addr_q : wrap ? '0 : addr_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q <= '0;
      addr_q <= '0;
    end else begin
      ch_q <= ch_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: rtl/conv_tile_loader.sv
// conv_tile_loader: fills ifm then weight tile buffers from a valid/ready stream, then launches the conv.
module conv_tile_loader #(
  parameter int NCH = cnn_pkg::NCH_DEF,
  parameter int NWORD = cnn_pkg::NWORD_DEF,
  parameter int DW = cnn_pkg::DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               nif,
  input  logic [7:0]               nwords,
  input  logic                     s_valid,
  input  logic [DW-1:0]            s_data,
  output logic                     s_ready,
  output logic                     buf_we,
  output logic                     buf_sel,
  output logic [$clog2(NCH)-1:0]   buf_ch,
  output logic [$clog2(NWORD)-1:0] buf_addr,
  output logic [DW-1:0]            buf_wdata,
  output logic                     conv_run,
  input  logic                     conv_done,
  output logic                     busy,
  output logic                     cfg_err
);
  import cnn_pkg::*;
  ld_state_e state_q, state_d;
  logic [7:0] nif_q, nwords_q;
  logic cfg_err_q, we_q, sel_q;
  logic [$clog2(NCH)-1:0] ch_q, gen_ch;
  logic [$clog2(NWORD)-1:0] addr_q, gen_addr;
  logic [DW-1:0] wdata_q;
  logic gen_last, legal, req, go, acc, clr;
  assign legal = nif != 8'd0 && nif <= 8'(NCH) && nwords != 8'd0 && nwords <= 8'(NWORD);
  assign req = state_q == IDLE && start;
  assign go = req && legal;
  assign s_ready = state_q == LOAD_IFM || state_q == LOAD_WGT;
  assign acc = s_valid && s_ready;
  // Counters restart on tile launch and at each buffer boundary.
  assign clr = go || (acc && gen_last);
  tile_addr_gen #(.NCH(NCH), .NWORD(NWORD)) u_addr (
    .clk(clk),
    .rst_n(rst_n),
    .clr_i(clr),
    .en_i(acc),
    .nif_i(nif_q),
    .nwords_i(nwords_q),
    .ch_o(gen_ch),
    .addr_o(gen_addr),
    .last_o(gen_last)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = go ? LOAD_IFM : IDLE;
      LOAD_IFM:  state_d = (acc && gen_last) ? LOAD_WGT : LOAD_IFM;
      LOAD_WGT:  state_d = (acc && gen_last) ? RUN : LOAD_WGT;
      RUN:       state_d = WAIT_DONE;
      WAIT_DONE: state_d = conv_done ? IDLE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nif_q <= '0;
      nwords_q <= '0;
      cfg_err_q <= 1'b0;
      we_q <= 1'b0;
      sel_q <= SEL_IFM;
      ch_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_err_q <= req && !legal;
      we_q <= acc;
      if (go) begin
        nif_q <= nif;
        nwords_q <= nwords;
      end
      if (acc) begin
        sel_q <= state_q == LOAD_WGT ? SEL_WGT : SEL_IFM;
        ch_q <= gen_ch;
        addr_q <= gen_addr;
        wdata_q <= s_data;
      end
    end
  end
  assign buf_we = we_q;
  assign buf_sel = sel_q;
  assign buf_ch = ch_q;
  assign buf_addr = addr_q;
  assign buf_wdata = wdata_q;
  assign conv_run = state_q == RUN;
  assign busy = state_q != IDLE;
  assign cfg_err = cfg_err_q;
endmodule
